calc1: RTL and testbench

// - Four-port, two-operand 32-bit calculator; each port carries an independent request/response channel.
// - Ops: add, subtract, shift left, shift right.
// - Per request: command + operand1, then operand2; a one-cycle response (code + data) follows.
// - Sits between four requesters and a shared clock/reset domain; no arbitration, ports never interact.

---
 rtl/calc1_pkg.sv | 25 ++
 rtl/calc1_port.sv | 104 ++++++++++
 rtl/calc1.sv | 67 ++++++
 tb/tb_calc1.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/calc1_pkg.sv
// calc1_pkg: shared encodings for the four-port calculator.
// Command and response codes, plus the per-port FSM state type.
package calc1_pkg;

    localparam int DATA_W = 32;
    localparam int CMD_W  = 4;
    localparam int RESP_W = 2;

    localparam logic [CMD_W-1:0] CMD_NOP = 4'd0;
    localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
    localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
    localparam logic [CMD_W-1:0] CMD_SHL = 4'd5;
    localparam logic [CMD_W-1:0] CMD_SHR = 4'd6;

    localparam logic [RESP_W-1:0] RESP_NONE = 2'd0;
    localparam logic [RESP_W-1:0] RESP_OK   = 2'd1;
    localparam logic [RESP_W-1:0] RESP_ERR  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OP2  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/calc1_port.sv
// calc1_port: one independent request/response channel (FSM + ALU).
// Optional feature macro: CALC1_RESP_HOLD_EN -- when defined, the last
// resp/data is held until the next command is accepted; otherwise the
// response is a one-cycle pulse.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for a nonzero command; latches cmd + operand1
// ST_OP2  | latches operand2, computes result into the output registers
// ST_RESP | response valid this cycle; a new command may be accepted
module calc1_port
    import calc1_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [CMD_W-1:0]   i_cmd,
    input  logic [DATA_W-1:0]  i_data,
    output logic [RESP_W-1:0]  o_resp,
    output logic [DATA_W-1:0]  o_data
);

    state_e              r_state;
    logic [CMD_W-1:0]    r_cmd;
    logic [DATA_W-1:0]   r_op1;

    logic [DATA_W:0]     w_sum;
    logic [4:0]          w_shamt;
    logic [RESP_W-1:0]   w_resp;
    logic [DATA_W-1:0]   w_data;

    // ALU: latched cmd/op1 combined with op2 arriving on i_data in ST_OP2
    always_comb begin
        w_sum   = {1'b0, r_op1} + {1'b0, i_data};
        w_shamt = i_data[4:0];
        w_resp  = RESP_ERR;
        w_data  = '0;
        case (r_cmd)
            CMD_ADD: begin
                if (!w_sum[DATA_W]) begin
                    w_resp = RESP_OK;
                    w_data = w_sum[DATA_W-1:0];
                end
            end
            CMD_SUB: begin
                if (i_data <= r_op1) begin
                    w_resp = RESP_OK;
                    w_data = r_op1 - i_data;
                end
            end
            CMD_SHL: begin
                w_resp = RESP_OK;
                w_data = r_op1 << w_shamt;
            end
            CMD_SHR: begin
                w_resp = RESP_OK;
                w_data = r_op1 >> w_shamt;
            end
            default: begin
                w_resp = RESP_ERR;
                w_data = '0;
            end
        endcase
    end

    // Request sequencing with registered response outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cmd   <= CMD_NOP;
            r_op1   <= '0;
            o_resp  <= RESP_NONE;
            o_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_RESP: begin
                    if (i_cmd != CMD_NOP) begin
                        r_cmd   <= i_cmd;
                        r_op1   <= i_data;
                        r_state <= ST_OP2;
                        o_resp  <= RESP_NONE;
                        o_data  <= '0;
                    end else begin
                        r_state <= ST_IDLE;
`ifndef CALC1_RESP_HOLD_EN
                        o_resp  <= RESP_NONE;
                        o_data  <= '0;
`endif
                    end
                end
                ST_OP2: begin
                    o_resp  <= w_resp;
                    o_data  <= w_data;
                    r_state <= ST_RESP;
                end
                default: begin
                    r_state <= ST_IDLE;
                    o_resp  <= RESP_NONE;
                    o_data  <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/calc1.sv
// calc1: four-port, two-operand 32-bit calculator (wiring only).
// Each port is an independent calc1_port; only reset[1] is used.
// Optional feature macro: CALC1_RESP_HOLD_EN (handled in calc1_port).
module calc1
    import calc1_pkg::*;
(
    output logic [0:31] out_data1,
    output logic [0:31] out_data2,
    output logic [0:31] out_data3,
    output logic [0:31] out_data4,
    output logic [0:1]  out_resp1,
    output logic [0:1]  out_resp2,
    output logic [0:1]  out_resp3,
    output logic [0:1]  out_resp4,
    input  logic        c_clk,
    input  logic [0:3]  req1_cmd_in,
    input  logic [0:31] req1_data_in,
    input  logic [0:3]  req2_cmd_in,
    input  logic [0:31] req2_data_in,
    input  logic [0:3]  req3_cmd_in,
    input  logic [0:31] req3_data_in,
    input  logic [0:3]  req4_cmd_in,
    input  logic [0:31] req4_data_in,
    input  logic [1:7]  reset
);

    logic w_rst;

    assign w_rst = reset[1];

    calc1_port u_port1 (
        .i_clk  (c_clk),
        .i_rst  (w_rst),
        .i_cmd  (req1_cmd_in),
        .i_data (req1_data_in),
        .o_resp (out_resp1),
        .o_data (out_data1)
    );

    calc1_port u_port2 (
        .i_clk  (c_clk),
        .i_rst  (w_rst),
        .i_cmd  (req2_cmd_in),
        .i_data (req2_data_in),
        .o_resp (out_resp2),
        .o_data (out_data2)
    );

    calc1_port u_port3 (
        .i_clk  (c_clk),
        .i_rst  (w_rst),
        .i_cmd  (req3_cmd_in),
        .i_data (req3_data_in),
        .o_resp (out_resp3),
        .o_data (out_data3)
    );

    calc1_port u_port4 (
        .i_clk  (c_clk),
        .i_rst  (w_rst),
        .i_cmd  (req4_cmd_in),
        .i_data (req4_data_in),
        .o_resp (out_resp4),
        .o_data (out_data4)
    );

endmodule

// File: tb/tb_calc1.sv
// tb_calc1: directed + randomized self-checking bench for calc1.
module tb_calc1;

    logic        c_clk;
    logic [1:7]  rst_v;
    logic [0:3]  cmd [4];
    logic [0:31] din [4];
    logic [0:31] dout [4];
    logic [0:1]  resp [4];

    logic [1:0]  held_resp [4];
    logic [31:0] held_data [4];

    int checks = 0;
    int errors = 0;

    calc1 dut (
        .out_data1    (dout[0]),
        .out_data2    (dout[1]),
        .out_data3    (dout[2]),
        .out_data4    (dout[3]),
        .out_resp1    (resp[0]),
        .out_resp2    (resp[1]),
        .out_resp3    (resp[2]),
        .out_resp4    (resp[3]),
        .c_clk        (c_clk),
        .req1_cmd_in  (cmd[0]),
        .req1_data_in (din[0]),
        .req2_cmd_in  (cmd[1]),
        .req2_data_in (din[1]),
        .req3_cmd_in  (cmd[2]),
        .req3_data_in (din[2]),
        .req4_cmd_in  (cmd[3]),
        .req4_data_in (din[3]),
        .reset        (rst_v)
    );

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned 32-bit arithmetic on wide integers
    function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                  output logic [1:0] r, output logic [31:0] d);
        logic [63:0] la;
        logic [63:0] lb;
        logic [63:0] pw;
        la = {32'd0, a};
        lb = {32'd0, b};
        pw = 64'd1 << (b % 32);
        r = 2'd2;
        d = 32'd0;
        case (c)
            4'd1: if (la + lb < 64'h1_0000_0000) begin r = 2'd1; d = 32'(la + lb); end
            4'd2: if (lb <= la) begin r = 2'd1; d = 32'(la - lb); end
            4'd5: begin r = 2'd1; d = 32'((la * pw) % 64'h1_0000_0000); end
            4'd6: begin r = 2'd1; d = 32'(la / pw); end
            default: ;
        endcase
    endfunction

    function automatic logic [1:0] idle_resp(input int p);
`ifdef CALC1_RESP_HOLD_EN
        return held_resp[p];
`else
        return 2'd0;
`endif
    endfunction

    function automatic logic [31:0] idle_data(input int p);
`ifdef CALC1_RESP_HOLD_EN
        return held_data[p];
`else
        return 32'd0;
`endif
    endfunction

    // One full request on port p: cmd+op1, op2 (with junk cmd), response, idle
    task automatic run(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] er, input logic [31:0] ed, input string tag);
        cmd[p] = c;
        din[p] = a;
        tick();
        cmd[p] = 4'($urandom);
        din[p] = b;
        tick();
        cmd[p] = 4'd0;
        din[p] = $urandom;
        check({tag, " resp"}, 32'(resp[p]), 32'(er));
        check({tag, " data"}, dout[p], ed);
        held_resp[p] = er;
        held_data[p] = ed;
        tick();
        check({tag, " idle resp"}, 32'(resp[p]), 32'(idle_resp(p)));
        check({tag, " idle data"}, dout[p], idle_data(p));
    endtask

    initial begin
        logic [1:0]  er;
        logic [31:0] ed;
        logic [31:0] x;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  c;
        int          p;

        for (int i = 0; i < 4; i++) begin
            cmd[i] = 4'd0;
            din[i] = 32'd0;
            held_resp[i] = 2'd0;
            held_data[i] = 32'd0;
        end
        rst_v = 7'b1000000;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset resp%0d", i + 1), 32'(resp[i]), 32'd0);
            check($sformatf("reset data%0d", i + 1), dout[i], 32'd0);
        end
        // unused reset bits high: must have no effect
        rst_v = 7'b0111111;

        // all ports nop with random data
        for (int cyc = 0; cyc < 4; cyc++) begin
            for (int i = 0; i < 4; i++) din[i] = $urandom;
            tick();
            for (int i = 0; i < 4; i++) begin
                check($sformatf("nop c%0d resp%0d", cyc, i + 1), 32'(resp[i]), 32'd0);
                check($sformatf("nop c%0d data%0d", cyc, i + 1), dout[i], 32'd0);
            end
        end

        // simultaneous add 2+3 on all ports
        for (int i = 0; i < 4; i++) begin cmd[i] = 4'd1; din[i] = 32'd2; end
        tick();
        for (int i = 0; i < 4; i++) begin cmd[i] = 4'd0; din[i] = 32'd3; end
        tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("par resp%0d", i + 1), 32'(resp[i]), 32'd1);
            check($sformatf("par data%0d", i + 1), dout[i], 32'd5);
            held_resp[i] = 2'd1;
            held_data[i] = 32'd5;
        end
        tick();
        for (int i = 0; i < 4; i++)
            check($sformatf("par idle resp%0d", i + 1), 32'(resp[i]), 32'(idle_resp(i)));

        // directed port1 cases
        run(0, 4'd1, 32'h0000_0001, 32'h1FFF_FFFF, 2'd1, 32'h2000_0000, "add ok");
        run(0, 4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'd0, "add ovf");
        run(0, 4'd2, 32'h1, 32'hF, 2'd2, 32'd0, "sub unf");
        run(0, 4'd2, 32'hF, 32'h1, 2'd1, 32'hE, "sub ok");
        run(0, 4'd2, 32'h1234, 32'h1234, 2'd1, 32'd0, "sub eq");
        run(0, 4'd3, 32'h1, 32'h1, 2'd2, 32'd0, "cmd3");
        run(0, 4'd4, 32'h1, 32'h1, 2'd2, 32'd0, "cmd4");
        run(0, 4'd5, 32'h8000_0001, 32'h21, 2'd1, 32'h0000_0002, "shl wrap amt");

        // walking bit shifts
        for (int k = 0; k < 30; k++) begin
            x = 32'd1 << k;
            run(0, 4'd5, x, 32'd1, 2'd1, x << 1, $sformatf("shl k%0d", k));
            x = 32'h8000_0000 >> k;
            run(0, 4'd6, x, 32'd1, 2'd1, x >> 1, $sformatf("shr k%0d", k));
        end

        // back-to-back on port 3: second cmd accepted in response cycle
        cmd[2] = 4'd1; din[2] = 32'd100;
        tick();
        cmd[2] = 4'd0; din[2] = 32'd23;
        tick();
        check("b2b first resp", 32'(resp[2]), 32'd1);
        check("b2b first data", dout[2], 32'd123);
        cmd[2] = 4'd2; din[2] = 32'd50;
        tick();
        check("b2b accept clr resp", 32'(resp[2]), 32'd0);
        check("b2b accept clr data", dout[2], 32'd0);
        cmd[2] = 4'd0; din[2] = 32'd8;
        tick();
        check("b2b second resp", 32'(resp[2]), 32'd1);
        check("b2b second data", dout[2], 32'd42);
        held_resp[2] = 2'd1;
        held_data[2] = 32'd42;
        tick();
        check("b2b idle resp", 32'(resp[2]), 32'(idle_resp(2)));

        // randomized requests against the model
        for (int n = 0; n < 80; n++) begin
            p = $urandom_range(0, 3);
            c = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 1) == 1) begin
                a = $urandom_range(0, 255);
                b = $urandom_range(0, 255);
            end else begin
                a = $urandom;
                b = $urandom;
            end
            model(c, a, b, er, ed);
            run(p, c, a, b, er, ed, $sformatf("rnd%0d p%0d c%0d", n, p + 1, c));
        end

        // reset during port1 OP2 while port2 is in its response cycle
        cmd[1] = 4'd1; din[1] = 32'd10;
        tick();
        cmd[1] = 4'd0; din[1] = 32'd20;
        cmd[0] = 4'd1; din[0] = 32'd5;
        tick();
        cmd[0] = 4'd0; din[0] = 32'd7;
        check("pre-rst p2 resp", 32'(resp[1]), 32'd1);
        check("pre-rst p2 data", dout[1], 32'd30);
        #2;
        rst_v = 7'b1000000;
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst async resp%0d", i + 1), 32'(resp[i]), 32'd0);
            check($sformatf("rst async data%0d", i + 1), dout[i], 32'd0);
            held_resp[i] = 2'd0;
            held_data[i] = 32'd0;
        end
        tick();
        tick();
        rst_v = 7'b0111111;
        for (int cyc = 0; cyc < 3; cyc++) begin
            tick();
            check($sformatf("post-rst c%0d resp1", cyc), 32'(resp[0]), 32'd0);
            check($sformatf("post-rst c%0d data1", cyc), dout[0], 32'd0);
        end
        run(0, 4'd1, 32'd5, 32'd7, 2'd1, 32'd12, "post-rst add");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
